// File: rtl/studio2_pkg.sv
// studio2_pkg: shared owner/state encodings and the console address map
package studio2_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_DMA, OWN_CPU} owner_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam logic [15:0] ROM_END     = 16'h07FF;
  localparam logic [15:0] RAM_BASE    = 16'h0800;
  localparam logic [15:0] MIRROR_BASE = 16'h0C00;
  localparam logic [15:0] RAM_SIZE    = 16'h0200;
endpackage

// File: rtl/studio2_addr_decode.sv
// studio2_addr_decode: maps CPU addresses onto the 4 KB memory image and flags ROM writes
module studio2_addr_decode
  import studio2_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_wr,
  output logic [ADDR_W-1:0] mapped_addr,
  output logic              hit,
  output logic              wr_ok
);
  logic rom, ram, mir;
  always_comb begin
    rom = cpu_addr <= ROM_END;
    ram = cpu_addr >= RAM_BASE && cpu_addr < RAM_BASE + RAM_SIZE;
    mir = cpu_addr >= MIRROR_BASE && cpu_addr < MIRROR_BASE + RAM_SIZE;
    hit = rom | ram | mir;
    wr_ok = !cpu_wr | ram | mir;
    mapped_addr = ADDR_W'(mir ? cpu_addr - (MIRROR_BASE - RAM_BASE) : cpu_addr);
  end
endmodule

// File: rtl/studio2_mem_arbiter.sv
// studio2_mem_arbiter: single-owner scheduler for the Studio II memory port (dl > dma > cpu)
module studio2_mem_arbiter
  import studio2_pkg::*;
#(
  parameter int          ADDR_W        = 12,
  parameter int          DMA_BURST_MAX = 8,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_req,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_din,
  output logic              dl_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic [7:0]        dma_dout,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait_n,
  output logic              ro_viol,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);
  localparam int CNT_W = $clog2(DMA_BURST_MAX + 1);
  state_t state, state_n;
  owner_t owner, grant;
  logic [CNT_W-1:0] burst, burst_n;
  logic [ADDR_W-1:0] l_addr, dec_addr;
  logic [7:0] l_din, dma_q, cpu_q;
  logic l_we, l_ce, l_unmap, l_viol, l_rd;
  logic cpu_pend, force_cpu, dec_hit, dec_wr_ok;

  studio2_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
    .cpu_addr    (cpu_addr),
    .cpu_wr      (cpu_wr),
    .mapped_addr (dec_addr),
    .hit         (dec_hit),
    .wr_ok       (dec_wr_ok)
  );

  always_comb begin
    cpu_pend = cpu_rd | cpu_wr;
    force_cpu = burst == CNT_W'(DMA_BURST_MAX) && cpu_pend;
    grant = state != ST_IDLE ? OWN_NONE : force_cpu ? OWN_CPU : dl_req ? OWN_DL :
            dma_req ? OWN_DMA : cpu_pend ? OWN_CPU : OWN_NONE;
    state_n = state == ST_IDLE ? (grant != OWN_NONE ? ST_ACCESS : ST_IDLE) :
              state == ST_ACCESS ? ST_RESP : ST_IDLE;
    burst_n = state != ST_IDLE ? burst : grant == OWN_CPU ? '0 :
              grant == OWN_DMA ? (burst == CNT_W'(DMA_BURST_MAX) ? burst : burst + 1'b1) :
              !dma_req ? '0 : burst;
    mem_ce = state == ST_ACCESS && l_ce;
    mem_we = mem_ce && l_we;
    mem_addr = l_addr;
    mem_din = l_din;
    dl_ack = state == ST_RESP && owner == OWN_DL;
    dma_ack = state == ST_RESP && owner == OWN_DMA;
    cpu_ack = state == ST_RESP && owner == OWN_CPU;
    ro_viol = state == ST_RESP && l_viol;
    dma_dout = dma_ack ? mem_dout : dma_q;
    cpu_dout = cpu_ack && l_rd ? (l_unmap ? UNMAPPED_DATA : mem_dout) : cpu_q;
    cpu_wait_n = !(cpu_pend && owner != OWN_CPU) || cpu_ack;
  end

  // Operands are captured at grant so requesters may move on while the access runs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      burst <= '0;
      l_addr <= '0;
      l_din <= '0;
      l_we <= 1'b0;
      l_ce <= 1'b0;
      l_unmap <= 1'b0;
      l_viol <= 1'b0;
      l_rd <= 1'b0;
      dma_q <= '0;
      cpu_q <= '0;
    end else begin
      state <= state_n;
      burst <= burst_n;
      dma_q <= dma_dout;
      cpu_q <= cpu_dout;
      if (state == ST_RESP) owner <= OWN_NONE;
      if (grant != OWN_NONE) begin
        owner <= grant;
        l_addr <= grant == OWN_DL ? dl_addr : grant == OWN_DMA ? dma_addr : dec_addr;
        l_din <= grant == OWN_DL ? dl_din : cpu_din;
        l_we <= grant == OWN_DL ? dl_wr : grant == OWN_CPU && cpu_wr && dec_hit && dec_wr_ok;
        l_ce <= grant != OWN_CPU || (dec_hit && dec_wr_ok);
        l_unmap <= grant == OWN_CPU && !dec_hit;
        l_viol <= grant == OWN_CPU && dec_hit && !dec_wr_ok;
        l_rd <= grant == OWN_CPU && !cpu_wr;
      end
    end
  end
endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// tb_studio2_mem_arbiter: random requesters against a transaction-level reference model
module tb_studio2_mem_arbiter;
  localparam int BURST = 8;
  logic clk_sys = 1'b0, reset = 1'b1;
  logic dl_req = 0, dl_wr = 0, dma_req = 0, cpu_rd = 0, cpu_wr = 0;
  logic [11:0] dl_addr = 0, dma_addr = 0;
  logic [7:0] dl_din = 0, cpu_din = 0;
  logic [15:0] cpu_addr = 0;
  logic dl_ack, dma_ack, cpu_ack, cpu_wait_n, ro_viol, mem_ce, mem_we;
  logic [7:0] dma_dout, cpu_dout, mem_din, mem_dout;
  logic [11:0] mem_addr;
  logic [7:0] phys [0:4095];
  logic [7:0] ref_mem [0:4095];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int free_at, run, t_start, t_who, dma_since, p_dl, p_dma, p_cpu;
  logic t_valid, t_ce, t_we, t_viol, t_rd, phase_burst;
  logic [11:0] t_addr;
  logic [7:0] t_din, t_exp;

  always #5 clk_sys = ~clk_sys;

  studio2_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_dout(dma_dout),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n), .ro_viol(ro_viol),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always @(posedge clk_sys) if (mem_ce) begin
    if (mem_we) phys[mem_addr] <= mem_din;
    mem_dout <= phys[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [12:0] cpu_map(input logic [15:0] a);
    if (a < 16'h0A00) return {1'b1, a[11:0]};
    if (a >= 16'h0C00 && a < 16'h0E00) return {1'b1, a[11:0] - 12'h400};
    return 13'h0;
  endfunction

  function automatic logic [15:0] rand_cpu_addr();
    case ($urandom_range(0, 5))
      0: return 16'($urandom_range(0, 16'h07FF));
      1: return 16'h0800 + 16'($urandom_range(0, 511));
      2: return 16'h0A00 + 16'($urandom_range(0, 511));
      3: return 16'h0C00 + 16'($urandom_range(0, 511));
      4: return 16'h0E00 + 16'($urandom_range(0, 511));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step();
    logic in_acc, in_rsp, pend;
    logic [12:0] m;
    int who, k;
    in_acc = t_valid && cyc == t_start + 1;
    in_rsp = t_valid && cyc == t_start + 2;
    pend = cpu_rd | cpu_wr;
    check("mem_ce", mem_ce, in_acc && t_ce);
    if (in_acc && t_ce) begin
      check("mem_addr", mem_addr, t_addr);
      check("mem_we", mem_we, t_we);
      if (t_we) check("mem_din", mem_din, t_din);
    end
    check("dl_ack", dl_ack, in_rsp && t_who == 1);
    check("dma_ack", dma_ack, in_rsp && t_who == 2);
    check("cpu_ack", cpu_ack, in_rsp && t_who == 3);
    check("ro_viol", ro_viol, in_rsp && t_viol);
    if (in_rsp && t_who == 2) check("dma_dout", dma_dout, t_exp);
    if (in_rsp && t_who == 3 && t_rd) check("cpu_dout", cpu_dout, t_exp);
    check("cpu_wait_n", cpu_wait_n,
          !(pend && !((in_acc || in_rsp) && t_who == 3)) || (in_rsp && t_who == 3));
    if (in_rsp && t_who == 2) dma_since++;
    if (in_rsp && t_who == 3) begin
      if (phase_burst) check("burst_len", dma_since, BURST);
      dma_since = 0;
    end
    if (in_rsp) begin
      if (t_who == 1) dl_req = 0;
      if (t_who == 2) dma_req = 0;
      if (t_who == 3) begin cpu_rd = 0; cpu_wr = 0; end
      t_valid = 0;
    end
    // granted requesters wiggle their operands to prove the arbiter latched them
    if (t_valid && t_who == 1) begin dl_addr = 12'($urandom); dl_din = 8'($urandom); dl_wr = 1'($urandom); end
    if (t_valid && t_who == 2) dma_addr = 12'($urandom);
    if (t_valid && t_who == 3) begin cpu_addr = 16'($urandom); cpu_din = 8'($urandom); end
    if (!dl_req && $urandom_range(0, 99) < p_dl) begin
      dl_req = 1; dl_wr = 1'($urandom); dl_din = 8'($urandom);
      dl_addr = $urandom_range(0, 1) ? 12'h800 + 12'($urandom_range(0, 511)) : 12'($urandom);
    end
    if (!dma_req && $urandom_range(0, 99) < p_dma) begin
      dma_req = 1; dma_addr = 12'($urandom);
    end
    if (!cpu_rd && !cpu_wr && $urandom_range(0, 99) < p_cpu) begin
      k = $urandom_range(0, 3);
      cpu_rd = k != 1; cpu_wr = k == 1 || k == 2;
      cpu_addr = rand_cpu_addr(); cpu_din = 8'($urandom);
    end
    if (cyc >= free_at) begin
      who = 0;
      if (run == BURST && (cpu_rd || cpu_wr)) who = 3;
      else if (dl_req) who = 1;
      else if (dma_req) who = 2;
      else if (cpu_rd || cpu_wr) who = 3;
      if (who == 2) run = run < BURST ? run + 1 : run;
      else if (who == 3 || !dma_req) run = 0;
      if (who != 0) begin
        t_valid = 1; t_start = cyc; free_at = cyc + 3; t_who = who;
        t_viol = 0; t_rd = 0; t_exp = 0; t_ce = 1; t_we = 0; t_din = 0;
        if (who == 1) begin
          t_we = dl_wr; t_addr = dl_addr; t_din = dl_din;
          if (dl_wr) ref_mem[dl_addr] = dl_din;
        end else if (who == 2) begin
          t_addr = dma_addr; t_exp = ref_mem[dma_addr];
        end else begin
          m = cpu_map(cpu_addr);
          t_rd = !cpu_wr; t_we = cpu_wr; t_din = cpu_din; t_addr = m[11:0];
          if (!m[12]) begin t_ce = 0; t_exp = 8'hFF; end
          else if (cpu_wr && cpu_addr < 16'h0800) begin t_ce = 0; t_viol = 1; end
          else if (cpu_wr) ref_mem[m[11:0]] = cpu_din;
          else t_exp = ref_mem[m[11:0]];
        end
      end
    end
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 8'($urandom); phys[i] = v; ref_mem[i] = v;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 0;
    check("rst_mem_ce", mem_ce, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_acks", {dl_ack, dma_ack, cpu_ack, ro_viol}, 0);
    check("rst_wait_n", cpu_wait_n, 1);
    check("rst_dma_dout", dma_dout, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    t_valid = 0; free_at = cyc; run = 0; dma_since = 0;
    phase_burst = 1; p_dl = 0; p_dma = 100; p_cpu = 100;
    repeat (80) step();
    phase_burst = 0; p_dl = 15; p_dma = 60; p_cpu = 50;
    repeat (3000) step();
    p_dl = 0; p_dma = 0; p_cpu = 0;
    repeat (12) step();
    dma_addr = 12'h345; dma_req = 1;
    @(posedge clk_sys); #1;
    check("rst_test_ce", mem_ce, 1);
    check("rst_test_addr", mem_addr, 12'h345);
    reset = 1; dma_req = 0;
    @(posedge clk_sys); #1;
    reset = 0;
    check("rst_abandon_ack", dma_ack, 0);
    check("rst_abandon_ce", mem_ce, 0);
    check("rst_abandon_wait", cpu_wait_n, 1);
    @(posedge clk_sys); #1;
    check("rst_abandon_ack2", dma_ack, 0);
    t_valid = 0; free_at = cyc; run = 0; dma_since = 0;
    p_dl = 15; p_dma = 60; p_cpu = 50;
    repeat (300) step();
    p_dl = 0; p_dma = 0; p_cpu = 0;
    repeat (12) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
